byte_deinterleaver: RTL and testbench

Receive-side inverse of the transmit block interleaver. Sits after the descrambler and before the RS decoder. Buffers one interleaved frame of DEPTH RS codewords in a ping-pong RAM and re-emits the codewords one after another, in RS-encoder output order. Per-codeword sideband (`sop`, `last`, `is_parity`) is regenerated, so the output stream is byte-identical to the RS encoder's output stream.

---
 rtl/byte_deinterleaver.sv | 175 +++++++++++++++++
 tb/tb_byte_deinterleaver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_deinterleaver.sv
// Receive-side block deinterleaver: buffers DEPTH interleaved RS codewords in a ping-pong RAM and
// replays them codeword by codeword with regenerated sop/last/is_parity sideband.
module byte_deinterleaver #(
  parameter int unsigned DEPTH           = 2,
  parameter int unsigned RS_K            = 223,
  parameter int unsigned RS_PARITY_BYTES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_axis_valid,
  output logic       s_axis_ready,
  input  logic [7:0] s_axis_data,
  input  logic       s_axis_sop,
  input  logic       s_axis_last,
  input  logic       s_axis_is_parity,
  output logic       m_axis_valid,
  input  logic       m_axis_ready,
  output logic [7:0] m_axis_data,
  output logic       m_axis_sop,
  output logic       m_axis_last,
  output logic       m_axis_is_parity,
  output logic       frame_err
);

  localparam int unsigned N     = RS_K + RS_PARITY_BYTES;
  localparam int unsigned FRAME = DEPTH * N;
  localparam int unsigned AW    = $clog2(2 * FRAME);
  localparam int unsigned JW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    r_mem [2*FRAME];

  logic          r_init;
  logic          r_err;
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic [CW-1:0] r_wr_c;
  logic [JW-1:0] r_wr_j;
  logic [AW-1:0] r_wr_base;
  logic          r_rd_bank;
  logic [AW-1:0] r_rd_addr;
  logic [JW-1:0] r_rd_j;
  logic          r_s1_valid, r_s1_sop, r_s1_last, r_s1_par;
  logic [7:0]    r_s1_data;
  logic          r_m_valid, r_m_sop, r_m_last, r_m_par;
  logic [7:0]    r_m_data;

  logic          w_wr_fire, w_at_zero, w_restart, w_eff_last, w_wr_done, w_frame_err;
  logic [CW-1:0] w_c;
  logic [JW-1:0] w_j;
  logic [AW-1:0] w_base, w_wr_addr, w_rd_ram_addr;
  logic          w_out_en, w_s1_en, w_rd_fire, w_rd_last, w_rd_done;
  logic [1:0]    w_full_d;
  logic          w_unused;

  assign w_unused = s_axis_is_parity;

  assign s_axis_ready     = r_init & ~r_full[r_wr_bank];
  assign m_axis_valid     = r_m_valid;
  assign m_axis_data      = r_m_data;
  assign m_axis_sop       = r_m_sop;
  assign m_axis_last      = r_m_last;
  assign m_axis_is_parity = r_m_par;
  assign frame_err        = r_err;

  // A sop away from position 0 restarts the frame, so this byte is written as p=0.
  always_comb begin
    w_wr_fire   = s_axis_valid & s_axis_ready;
    w_at_zero   = (r_wr_c == '0) && (r_wr_j == '0);
    w_restart   = s_axis_sop & ~w_at_zero;
    w_c         = w_restart ? '0 : r_wr_c;
    w_j         = w_restart ? '0 : r_wr_j;
    w_base      = w_restart ? '0 : r_wr_base;
    w_eff_last  = (w_c == CW'(DEPTH - 1)) && (w_j == JW'(N - 1));
    w_wr_addr   = (r_wr_bank ? AW'(FRAME) : '0) + w_base + AW'(w_j);
    w_wr_done   = w_wr_fire & w_eff_last;
    w_frame_err = w_wr_fire & ((s_axis_sop != w_at_zero) | (s_axis_last != w_eff_last));
  end

  always_comb begin
    w_out_en      = ~r_m_valid | m_axis_ready;
    w_s1_en       = ~r_s1_valid | w_out_en;
    w_rd_fire     = w_s1_en & r_full[r_rd_bank];
    w_rd_last     = (r_rd_addr == AW'(FRAME - 1));
    w_rd_done     = w_rd_fire & w_rd_last;
    w_rd_ram_addr = (r_rd_bank ? AW'(FRAME) : '0) + r_rd_addr;
  end

  // Write-complete and read-complete always target opposite banks, so both updates apply.
  always_comb begin
    w_full_d = r_full;
    if (w_wr_done) w_full_d[r_wr_bank] = 1'b1;
    if (w_rd_done) w_full_d[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[w_wr_addr] <= s_axis_data;
    if (w_rd_fire) r_s1_data <= r_mem[w_rd_ram_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init    <= 1'b0;
      r_err     <= 1'b0;
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_c    <= '0;
      r_wr_j    <= '0;
      r_wr_base <= '0;
    end else begin
      r_init <= 1'b1;
      r_err  <= w_frame_err;
      r_full <= w_full_d;
      if (w_wr_fire) begin
        if (w_eff_last) begin
          r_wr_c    <= '0;
          r_wr_j    <= '0;
          r_wr_base <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else if (w_c == CW'(DEPTH - 1)) begin
          r_wr_c    <= '0;
          r_wr_base <= '0;
          r_wr_j    <= w_j + JW'(1);
        end else begin
          r_wr_c    <= w_c + CW'(1);
          r_wr_base <= w_base + AW'(N);
          r_wr_j    <= w_j;
        end
      end
    end
  end

  // Two-stage read pipeline: RAM output register (s1) feeding the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank  <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_j     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_sop   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_par   <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= 8'h00;
      r_m_sop    <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_par    <= 1'b0;
    end else begin
      if (w_rd_fire) begin
        if (w_rd_last) begin
          r_rd_addr <= '0;
          r_rd_j    <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_addr <= r_rd_addr + AW'(1);
          r_rd_j    <= (r_rd_j == JW'(N - 1)) ? '0 : r_rd_j + JW'(1);
        end
      end
      if (w_s1_en) begin
        r_s1_valid <= w_rd_fire;
        r_s1_sop   <= (r_rd_j == '0);
        r_s1_last  <= (r_rd_j == JW'(N - 1));
        r_s1_par   <= (r_rd_j >= JW'(RS_K));
      end
      if (w_out_en) begin
        r_m_valid <= r_s1_valid;
        r_m_data  <= r_s1_data;
        r_m_sop   <= r_s1_sop;
        r_m_last  <= r_s1_last;
        r_m_par   <= r_s1_par;
      end
    end
  end

endmodule

// File: tb/tb_byte_deinterleaver.sv
// Scoreboard bench for byte_deinterleaver (DEPTH=2, N=255): frames are modelled in the bench,
// expected codeword-order bytes queued per completed frame and compared at each output handshake.
module tb_byte_deinterleaver;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned RS_K  = 223;
  localparam int unsigned RS_P  = 32;
  localparam int unsigned N     = RS_K + RS_P;
  localparam int unsigned FRAME = DEPTH * N;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0, s_ready, s_sop = 1'b0, s_last = 1'b0, s_par = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       m_valid, m_ready = 1'b0, m_sop, m_last, m_par, f_err;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  byte_deinterleaver #(
    .DEPTH          (DEPTH),
    .RS_K           (RS_K),
    .RS_PARITY_BYTES(RS_P)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_valid    (s_valid),
    .s_axis_ready    (s_ready),
    .s_axis_data     (s_data),
    .s_axis_sop      (s_sop),
    .s_axis_last     (s_last),
    .s_axis_is_parity(s_par),
    .m_axis_valid    (m_valid),
    .m_axis_ready    (m_ready),
    .m_axis_data     (m_data),
    .m_axis_sop      (m_sop),
    .m_axis_last     (m_last),
    .m_axis_is_parity(m_par),
    .frame_err       (f_err)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [10:0] sb[$];
  logic [10:0] sb_exp;
  logic [7:0]  frm[FRAME];
  int          rdy_mode = 0;  // 0 always ready, 1 random ~87%, 2 held low
  int unsigned cyc = 0, t_hs = 0, t_last = 0, cur_p = 0;
  int unsigned err_cnt = 0, gap_cnt = 0, srdy_low_cnt = 0, out_cnt = 0;
  bit          started = 0, lat_armed = 0, b2b_armed = 0;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_bus = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(99) < 87);
      default: m_ready = 1'b0;
    endcase
  end

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check_eq("hold", {m_valid, m_sop, m_last, m_par, m_data}, {1'b1, prev_bus});
      if (f_err) err_cnt++;
      if (b2b_armed) begin
        if (!s_ready) srdy_low_cnt++;
        if (started && !m_valid && sb.size() > 0) gap_cnt++;
      end
      if (m_valid) begin
        if (lat_armed) begin
          check_eq("latency", 64'(cyc - t_last), 64'd2);
          lat_armed = 0;
        end
        started = 1;
      end
      if (m_valid && m_ready) begin
        check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          sb_exp = sb.pop_front();
          check_eq("out_byte", {m_sop, m_last, m_par, m_data}, sb_exp);
          out_cnt++;
        end
      end
      prev_stall = m_valid & ~m_ready;
      prev_bus   = {m_sop, m_last, m_par, m_data};
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_byte(input logic [7:0] d, input logic sop, input logic last,
                           input int idle_pct);
    int n;
    while ($urandom_range(99) < idle_pct) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_sop   = sop;
    s_last  = last;
    s_par   = 1'($urandom);
    n = 0;
    while (!s_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check_eq("in_timeout", 64'(n), 64'd0);
      s_valid = 1'b0;
    end else begin
      @(negedge clk);
      t_hs = cyc;
    end
  endtask

  task automatic push_expected();
    int unsigned c, j;
    for (int unsigned k = 0; k < FRAME; k++) begin
      c = k / N;
      j = k % N;
      sb.push_back({j == 0, j == N - 1, j >= RS_K, frm[j*DEPTH + c]});
    end
  endtask

  // pat 0: value (p%2)*0x80 + p/2; pat 1: random. Only complete frames are scoreboarded.
  task automatic send_frame(input int pat, input int idle_pct, input int unsigned nbytes);
    for (int unsigned p = 0; p < FRAME; p++)
      frm[p] = (pat == 0) ? 8'((p % DEPTH) * 128 + p / DEPTH) : 8'($urandom);
    for (int unsigned p = 0; p < nbytes; p++) begin
      cur_p = p;
      send_byte(frm[p], p == 0, p == FRAME - 1, idle_pct);
    end
    if (nbytes == FRAME) push_expected();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drained", 64'(sb.size()), 64'd0);
    repeat (4) @(negedge clk);
    check_eq("idle_valid", 64'(m_valid), 64'd0);
  endtask

  int unsigned err0, out0;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_m_sop", 64'(m_sop), 64'd0);
    check_eq("rst_m_last", 64'(m_last), 64'd0);
    check_eq("rst_m_par", 64'(m_par), 64'd0);
    check_eq("rst_m_data", 64'(m_data), 64'h00);
    check_eq("rst_frame_err", 64'(f_err), 64'd0);
    check_eq("rst_s_ready", 64'(s_ready), 64'd0);
    rst_n = 1'b1;
    #1 check_eq("s_ready_pre_edge", 64'(s_ready), 64'd0);
    @(negedge clk);
    check_eq("s_ready_rise", 64'(s_ready), 64'd1);

    // Counting-pattern frame, always ready, latency check.
    send_frame(0, 0, FRAME);
    s_valid   = 1'b0;
    t_last    = t_hs;
    lat_armed = 1;
    wait_drain();
    check_eq("t1_count", 64'(out_cnt), 64'(FRAME));
    check_eq("t1_err", 64'(err_cnt), 64'd0);

    // Back-to-back frames: no s_ready drop, no output gaps.
    started = 0; gap_cnt = 0; srdy_low_cnt = 0; b2b_armed = 1;
    for (int i = 0; i < 3; i++) send_frame(1, 0, FRAME);
    s_valid = 1'b0;
    wait_drain();
    b2b_armed = 0;
    check_eq("b2b_s_ready_low", 64'(srdy_low_cnt), 64'd0);
    check_eq("b2b_gaps", 64'(gap_cnt), 64'd0);
    check_eq("b2b_err", 64'(err_cnt), 64'd0);

    // Output stalled: both banks fill, third frame blocked at p=0, then drains in order.
    out0 = out_cnt;
    rdy_mode = 2;
    send_frame(1, 0, FRAME);
    send_frame(1, 0, FRAME);
    fork
      send_frame(1, 0, FRAME);
      begin
        repeat (2000) @(negedge clk);
        check_eq("bp_s_ready", 64'(s_ready), 64'd0);
        check_eq("bp_stuck_p0", 64'(cur_p), 64'd0);
        check_eq("bp_m_valid", 64'(m_valid), 64'd1);
        check_eq("bp_out_none", 64'(out_cnt - out0), 64'd0);
        rdy_mode = 0;
      end
    join
    s_valid = 1'b0;
    wait_drain();
    check_eq("bp_count", 64'(out_cnt - out0), 64'(3 * FRAME));

    // Early sop at p=100 restarts the frame.
    err0 = err_cnt;
    send_frame(1, 0, 100);
    send_frame(1, 0, FRAME);
    s_valid = 1'b0;
    wait_drain();
    check_eq("sop_err_pulses", 64'(err_cnt - err0), 64'd1);

    // Reset while output is stalled and a frame is half written.
    rdy_mode = 2;
    send_frame(1, 0, FRAME);
    sb.delete();
    send_frame(1, 0, 300);
    check_eq("pre_rst_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(m_valid), 64'd0);
    check_eq("async_rst_data", 64'(m_data), 64'h00);
    check_eq("async_rst_s_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    @(negedge clk);
    err0 = err_cnt;
    send_frame(1, 50, FRAME);
    s_valid = 1'b0;
    wait_drain();
    check_eq("post_rst_err", 64'(err_cnt - err0), 64'd0);

    // Random valid and ready.
    for (int i = 0; i < 2; i++) send_frame(1, 50, FRAME);
    s_valid = 1'b0;
    wait_drain();
    check_eq("rand_err", 64'(err_cnt - err0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
